booth_mult_r4: RTL
==================

# booth_mult_r4

Parametrised, handshaked radix-4 Booth sequential multiplier. It is the next generation of the lab's fixed 32-bit free-running Booth multiplier, generalised in three ways:
- operand width is a parameter;
- signed or unsigned mode is selected per operation;
- free-running counter timing is replaced by valid/ready handshakes with output backpressure.

It retires one Booth digit per cycle and sits between an operand source and a result consumer in the lab datapath.

## Interface
- `WIDTH`, default 32: operand width; must be even and ≥ 4. Product width is 2·WIDTH.
- `CLK`  in  1  rising-edge clock.
- `RST`  in  1  reset; synchronous, active-high.
- `in_valid`  in  1  operand pair present.
- `in_ready`  out  1  block can accept operands.
- `in_a`  in  WIDTH  multiplicand.
- `in_b`  in  WIDTH  multiplier.
- `in_signed`  in  1  1 = two's-complement operands, 0 = unsigned; sampled with operands.
- `out_valid`  out  1  product valid.
- `out_ready`  in  1  consumer takes product.
- `product`  out  2·WIDTH  result.
- `busy`  out  1  high in CALC.

## Operation
- FSM states:
  - **IDLE**: `in_ready`=1.
  - **CALC**: one digit per cycle.
  - **DONE**: `out_valid`=1.
- Transitions:
  - IDLE→CALC on `in_valid`&&`in_ready`.
  - CALC→DONE after N = WIDTH/2+1 digit cycles.
  - DONE→IDLE on `out_valid`&&`out_ready`.
- On accept, register:
  - `in_a` extended to 2·WIDTH bits (sign- or zero-extended per `in_signed`) as multiplicand M.
  - `in_b` extended to WIDTH+2 bits (same rule), with an appended 0 LSB, as multiplier Q.
  - Clear the accumulator and the digit counter.
- Each CALC cycle, decode Q[2:0]:
  - 000/111: +0
  - 001/010: +M
  - 011: +2M
  - 100: −2M
  - 101/110: −M
  - Then M <<= 2, Q >>= 2 (arithmetic shift), counter += 1.
- The extra (N-th) digit makes unsigned operands correct. For signed operands it always decodes to 0.
- All accumulation is modulo 2^(2·WIDTH). No overflow flag, because the product always fits.
- `product` holds the accumulator. It is stable and meaningful only while `out_valid`=1.
- `in_signed` and operand inputs are ignored outside the accept cycle.

## Timing
- Reset values:
  - state IDLE
  - `in_ready`=1
  - `out_valid`=0
  - `busy`=0
  - `product`=0
  - counter 0
- Latency: if the accept is on edge k, `out_valid` rises after edge k+N. For WIDTH=32, N=17; for WIDTH=8, N=5.
- Backpressure: in DONE with `out_ready`=0, `out_valid` and `product` hold indefinitely, unchanged.
- Throughput:
  - The block does not accept new operands in the same cycle a result is consumed: `in_ready` is 0 in DONE.
  - The earliest next accept is the cycle after the handshake.
  - Sustained throughput is 1 product per N+2 cycles.
- `in_valid` while not in IDLE is ignored. The source must hold its data until it sees `in_ready`.
- `out_ready` outside DONE has no effect.
- `RST` asserted in any state, including mid-CALC or in DONE with an unconsumed result, returns all state to reset values on that edge. The in-flight operation is discarded with no `out_valid`.
- If `RST` and `in_valid` are asserted together, `RST` wins and nothing is accepted.

## Structure
- Shared package `booth_pkg` contains:
  - the state enum `booth_state_t` (IDLE, CALC, DONE);
  - the digit-select typedef `booth_sel_t` (ZERO, P1, P2, M1, M2);
  - a function giving N from WIDTH.
- Sub-module `booth_r4_encoder`: combinational, 3-bit window → `booth_sel_t`. It is reused by a future parallel multiplier.
- The top level holds the FSM, the M/Q/accumulator registers, the counter and the add/sub.

## Test plan
- WIDTH=32, signed, a=7, b=−3, `out_ready`=1 → `product`=0xFFFF_FFFF_FFFF_FFEB; `out_valid` exactly 17 edges after accept, high 1 cycle.
- WIDTH=32, unsigned, a=b=0xFFFF_FFFF → 0xFFFF_FFFE_0000_0001. The same bit patterns in signed mode → 0x0000_0000_0000_0001.
- WIDTH=32, signed, a=b=0x8000_0000 → 0x4000_0000_0000_0000. Also a=0, b=0x8000_0000 → 0.
- WIDTH=8, signed, a=−128, b=127 → 0xC080 after 5 cycles; unsigned a=0x80, b=0x7F → 0x3F80.
- Backpressure: hold `out_ready`=0 for 10 cycles in DONE → `product` and `out_valid` unchanged, `in_ready`=0, `in_valid` pulses ignored. Release → IDLE next cycle; the next operands are accepted and correct.
- `RST` pulse at the 8th CALC cycle → next cycle IDLE, `product`=0, `out_valid` never asserted for that operation; a following operation completes correctly.

Source files
------------

// File: rtl/booth_pkg.sv
// Shared types and helpers for the radix-4 Booth multiplier family.
package booth_pkg;

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    DONE
  } booth_state_t;

  typedef enum logic [2:0] {
    ZERO,
    P1,
    P2,
    M1,
    M2
  } booth_sel_t;

  // One digit per bit pair, plus one extra digit so unsigned operands come out right.
  function automatic int unsigned booth_digits(input int unsigned width);
    return width / 2 + 1;
  endfunction

endpackage

// File: rtl/booth_mult_r4_if.sv
// Operand/result handshake bundle for booth_mult_r4.
interface booth_mult_r4_if #(
  parameter int unsigned WIDTH = 32
);
  logic                 in_valid;
  logic                 in_ready;
  logic [WIDTH-1:0]     in_a;
  logic [WIDTH-1:0]     in_b;
  logic                 in_signed;
  logic                 out_valid;
  logic                 out_ready;
  logic [2*WIDTH-1:0]   product;
  logic                 busy;

  modport master (
    output in_valid, in_a, in_b, in_signed, out_ready,
    input  in_ready, out_valid, product, busy
  );

  modport slave (
    input  in_valid, in_a, in_b, in_signed, out_ready,
    output in_ready, out_valid, product, busy
  );
endinterface

// File: rtl/booth_r4_encoder.sv
// Radix-4 Booth recoder: 3-bit multiplier window to partial-product selection.
module booth_r4_encoder
  import booth_pkg::*;
(
  input  logic [2:0] window,
  output booth_sel_t sel
);

  always_comb begin
    sel = ZERO;
    case (window)
      3'b001, 3'b010: sel = P1;
      3'b011:         sel = P2;
      3'b100:         sel = M2;
      3'b101, 3'b110: sel = M1;
      default:        sel = ZERO;
    endcase
  end

endmodule

// File: rtl/booth_mult_r4.sv
// Handshaked sequential radix-4 Booth multiplier, one digit per cycle, signed or unsigned per operation.
module booth_mult_r4
  import booth_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic            CLK,
  input  logic            RST,
  booth_mult_r4_if.slave  bus
);

  localparam int unsigned N  = booth_digits(WIDTH);
  localparam int unsigned CW = $clog2(N + 1);
  localparam int unsigned PW = 2 * WIDTH;
  localparam int unsigned QW = WIDTH + 3;

  booth_state_t   state_q, state_d;
  logic [PW-1:0]  m_q, m_d;
  logic [QW-1:0]  q_q, q_d;
  logic [PW-1:0]  acc_q, acc_d;
  logic [CW-1:0]  cnt_q, cnt_d;

  booth_sel_t     sel;
  logic [PW-1:0]  m_x2;
  logic [PW-1:0]  addend;
  logic           a_sx;
  logic           b_sx;
  logic           last_digit;

  booth_r4_encoder u_enc (
    .window (q_q[2:0]),
    .sel    (sel)
  );

  assign m_x2       = {m_q[PW-2:0], 1'b0};
  assign a_sx       = bus.in_signed & bus.in_a[WIDTH-1];
  assign b_sx       = bus.in_signed & bus.in_b[WIDTH-1];
  assign last_digit = (cnt_q == CW'(N - 1));

  always_comb begin
    addend = '0;
    case (sel)
      P1:      addend = m_q;
      P2:      addend = m_x2;
      M1:      addend = -m_q;
      M2:      addend = -m_x2;
      default: addend = '0;
    endcase
  end

  always_comb begin
    state_d = state_q;
    m_d     = m_q;
    q_d     = q_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (bus.in_valid) begin
          m_d     = {{WIDTH{a_sx}}, bus.in_a};
          q_d     = {{2{b_sx}}, bus.in_b, 1'b0};
          acc_d   = '0;
          cnt_d   = '0;
          state_d = CALC;
        end
      end
      CALC: begin
        acc_d = acc_q + addend;
        m_d   = {m_q[PW-3:0], 2'b00};
        q_d   = {{2{q_q[QW-1]}}, q_q[QW-1:2]};
        cnt_d = cnt_q + CW'(1);
        if (last_digit) begin
          state_d = DONE;
        end
      end
      DONE: begin
        if (bus.out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= IDLE;
      m_q     <= '0;
      q_q     <= '0;
      acc_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      m_q     <= m_d;
      q_q     <= q_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
    end
  end

  assign bus.in_ready  = (state_q == IDLE);
  assign bus.out_valid = (state_q == DONE);
  assign bus.busy      = (state_q == CALC);
  assign bus.product   = acc_q;

endmodule
